// File: rtl/ifetch.sv
// ifetch: instruction fetch unit with a 2-entry output FIFO.
// Issues single-cycle-latency reads to an instruction memory, tags each
// returned word with its address, and hands words to the decoder over a
// valid/ready interface. Redirects flush the FIFO and drop the read in flight.
// Optional build macro: IFETCH_LOADER_EN adds a program-load port and the
// LOAD state, which writes one word into instruction memory per request.
module ifetch #(
    parameter int width    = 28,
    parameter int add_size = 11
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    input  logic                redirect_valid,
    input  logic [add_size-1:0] redirect_pc,
    output logic                inst_valid,
    input  logic                inst_ready,
    output logic [width-1:0]    inst,
    output logic [add_size-1:0] inst_pc,
    output logic                im_cs,
    output logic [1:0]          im_wen,
    output logic [add_size-1:0] im_address,
    output logic [width-1:0]    im_d,
    input  logic [width-1:0]    im_q
`ifdef IFETCH_LOADER_EN
    ,
    input  logic                ld_valid,
    output logic                ld_ready,
    input  logic [add_size-1:0] ld_addr,
    input  logic [width-1:0]    ld_data
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        LOAD = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [add_size-1:0] pc_q, pc_d;
    logic                inflight_q, inflight_d;
    logic [add_size-1:0] inflight_pc_q, inflight_pc_d;
    logic [width-1:0]    fifo_inst_q [2];
    logic [width-1:0]    fifo_inst_d [2];
    logic [add_size-1:0] fifo_pc_q [2];
    logic [add_size-1:0] fifo_pc_d [2];
    logic                rd_ptr_q, rd_ptr_d;
    logic                wr_ptr_q, wr_ptr_d;
    logic [1:0]          count_q, count_d;

    logic                pop;
    logic                push;
    logic                issue;
    logic [1:0]          count_after_pop;
    logic                ld_ready_int;
    logic                ld_accept;

`ifdef IFETCH_LOADER_EN
    logic [add_size-1:0] ld_addr_q, ld_addr_d;
    logic [width-1:0]    ld_data_q, ld_data_d;
`endif

    // Head of the FIFO is always presented; valid is masked while reset is high.
    assign inst_valid = !reset && (count_q != 2'd0);
    assign inst       = fifo_inst_q[rd_ptr_q];
    assign inst_pc    = fifo_pc_q[rd_ptr_q];
    assign pop        = inst_valid && inst_ready;

    // A head popped this cycle frees its slot, so a new read may be issued
    // against it; this is what sustains one instruction per cycle.
    assign count_after_pop = count_q - {1'b0, pop};
    assign issue = !reset && (state_q == RUN) && run && !redirect_valid &&
                   ((count_after_pop + {1'b0, inflight_q}) < 2'd2);

    // Memory data lands the cycle after issue; a redirect in that cycle drops it.
    assign push = inflight_q && !redirect_valid;

`ifdef IFETCH_LOADER_EN
    assign ld_ready_int = !reset && (state_q == IDLE) && !inflight_q && !run;
    assign ld_accept    = ld_valid && ld_ready_int;
    assign ld_ready     = ld_ready_int;
`else
    assign ld_ready_int = 1'b0;
    assign ld_accept    = 1'b0;
`endif

    // Memory interface: reads while issuing, one write cycle in LOAD.
    always_comb begin
        im_cs      = issue;
        im_wen     = 2'b00;
        im_address = issue ? pc_q : '0;
        im_d       = '0;
`ifdef IFETCH_LOADER_EN
        if (!reset && (state_q == LOAD)) begin
            im_cs      = 1'b1;
            im_wen     = 2'b11;
            im_address = ld_addr_q;
            im_d       = ld_data_q;
        end
`endif
    end

    // Next state for the fetch controller, pc and in-flight tracking.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        inflight_d    = issue;
        inflight_pc_d = pc_q;
        case (state_q)
            IDLE: begin
                if (run) begin
                    state_d = RUN;
                end else if (ld_accept) begin
                    state_d = LOAD;
                end
            end
            RUN: begin
                if (!run && !inflight_q) begin
                    state_d = IDLE;
                end
            end
            LOAD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (redirect_valid) begin
            pc_d = redirect_pc;
        end else if (issue) begin
            pc_d = pc_q + add_size'(1);
        end
    end

`ifdef IFETCH_LOADER_EN
    // Capture the accepted load request so LOAD can drive it for one cycle.
    always_comb begin
        ld_addr_d = ld_addr_q;
        ld_data_d = ld_data_q;
        if (ld_accept) begin
            ld_addr_d = ld_addr;
            ld_data_d = ld_data;
        end
    end
`endif

    // FIFO bookkeeping: redirect flushes everything, including a same-cycle pop.
    always_comb begin
        fifo_inst_d = fifo_inst_q;
        fifo_pc_d   = fifo_pc_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        if (redirect_valid) begin
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (push) begin
                fifo_inst_d[wr_ptr_q] = im_q;
                fifo_pc_d[wr_ptr_q]   = inflight_pc_q;
                wr_ptr_d              = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    // All state registers, cleared synchronously by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            pc_q          <= '0;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            rd_ptr_q      <= 1'b0;
            wr_ptr_q      <= 1'b0;
            count_q       <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                fifo_inst_q[i] <= '0;
                fifo_pc_q[i]   <= '0;
            end
`ifdef IFETCH_LOADER_EN
            ld_addr_q     <= '0;
            ld_data_q     <= '0;
`endif
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            fifo_inst_q   <= fifo_inst_d;
            fifo_pc_q     <= fifo_pc_d;
`ifdef IFETCH_LOADER_EN
            ld_addr_q     <= ld_addr_d;
            ld_data_q     <= ld_data_d;
`endif
        end
    end

endmodule

// File: tb/tb_ifetch.sv
// tb_ifetch: directed bench for ifetch with a one-cycle-latency memory model.
// Memory content is a fixed pattern (special words at 0..3 and 0x100) plus
// any words written through the loader port.
module tb_ifetch;

    localparam int W  = 28;
    localparam int AW = 11;

    localparam logic [W-1:0] WA = 28'h0A0A0A1;
    localparam logic [W-1:0] WB = 28'h0B0B0B2;
    localparam logic [W-1:0] WC = 28'h0C0C0C3;
    localparam logic [W-1:0] WD = 28'h0D0D0D4;
    localparam logic [W-1:0] WR = 28'h1234567;

    logic          clk = 1'b0;
    logic          reset;
    logic          run;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic          inst_valid;
    logic          inst_ready;
    logic [W-1:0]  inst;
    logic [AW-1:0] inst_pc;
    logic          im_cs;
    logic [1:0]    im_wen;
    logic [AW-1:0] im_address;
    logic [W-1:0]  im_d;
    logic [W-1:0]  im_q = '0;
`ifdef IFETCH_LOADER_EN
    logic          ld_valid;
    logic          ld_ready;
    logic [AW-1:0] ld_addr;
    logic [W-1:0]  ld_data;
`endif

    int checks = 0;
    int errors = 0;

    logic [W-1:0] wmem [2048];
    bit           wvalid [2048];

    ifetch #(.width(W), .add_size(AW)) dut (
        .clk(clk), .reset(reset), .run(run),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst(inst), .inst_pc(inst_pc),
        .im_cs(im_cs), .im_wen(im_wen), .im_address(im_address),
        .im_d(im_d), .im_q(im_q)
`ifdef IFETCH_LOADER_EN
        , .ld_valid(ld_valid), .ld_ready(ld_ready),
        .ld_addr(ld_addr), .ld_data(ld_data)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] base_word(input logic [AW-1:0] a);
        case (a)
            11'd0:   base_word = WA;
            11'd1:   base_word = WB;
            11'd2:   base_word = WC;
            11'd3:   base_word = WD;
            11'h100: base_word = WR;
            default: base_word = 28'h5500000 + {17'd0, a};
        endcase
    endfunction

    // Memory model: read data valid the cycle after the strobe.
    always @(posedge clk) begin
        if (im_cs) begin
            if (im_wen == 2'b11) begin
                wmem[im_address]   <= im_d;
                wvalid[im_address] <= 1'b1;
            end else if (im_wen == 2'b00) begin
                im_q <= wvalid[im_address] ? wmem[im_address] : base_word(im_address);
            end
        end
    end

    task automatic cyc;
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs;
        run = 1'b0; inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
`ifdef IFETCH_LOADER_EN
        ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
`endif
    endtask

    task automatic do_reset;
        reset = 1'b1;
        idle_inputs();
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        idle_inputs();
        cyc();
        #1;
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", inst_valid); end
        checks++; if (im_cs !== 1'b0) begin errors++; $display("FAIL rst_cs: got %b want 0", im_cs); end
        checks++; if (im_wen !== 2'b00) begin errors++; $display("FAIL rst_wen: got %b want 00", im_wen); end
        checks++; if (im_address !== 11'd0) begin errors++; $display("FAIL rst_addr: got %h want 0", im_address); end
        checks++; if (im_d !== 28'd0) begin errors++; $display("FAIL rst_d: got %h want 0", im_d); end
`ifdef IFETCH_LOADER_EN
        checks++; if (ld_ready !== 1'b0) begin errors++; $display("FAIL rst_ld_ready: got %b want 0", ld_ready); end
`endif
        cyc();
        reset = 1'b0;
        #1;
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL post_rst_valid: got %b want 0", inst_valid); end
        checks++; if (im_cs !== 1'b0) begin errors++; $display("FAIL post_rst_cs: got %b want 0", im_cs); end
        $display("test_reset done");
    endtask

    task automatic test_basic;
        logic [W-1:0] exp_w [4];
        exp_w = '{WA, WB, WC, WD};
        do_reset();
        run = 1'b1; inst_ready = 1'b1;
        cyc();   // edge that samples run: enters RUN
        #1;
        checks++; if (im_cs !== 1'b1 || im_address !== 11'd0) begin errors++; $display("FAIL basic_issue0: got cs=%b addr=%h want cs=1 addr=0", im_cs, im_address); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL basic_lat1: got valid=%b want 0", inst_valid); end
        cyc();
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL basic_lat2: got valid=%b want 0", inst_valid); end
        cyc();   // second edge after run was sampled: first word visible
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (inst_valid !== 1'b1 || inst_pc !== AW'(k) || inst !== exp_w[k]) begin
                errors++;
                $display("FAIL basic_seq%0d: got v=%b pc=%h inst=%h want v=1 pc=%h inst=%h", k, inst_valid, inst_pc, inst, k, exp_w[k]);
            end
            cyc();
        end
        $display("test_basic done");
    endtask

    task automatic test_stall;
        logic [W-1:0] exp_w [4];
        exp_w = '{WA, WB, WC, WD};
        do_reset();
        run = 1'b1; inst_ready = 1'b0;
        repeat (4) cyc();
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (im_cs !== 1'b0 || inst_valid !== 1'b1 || inst_pc !== 11'd0) begin
                errors++;
                $display("FAIL stall_hold%0d: got cs=%b v=%b pc=%h want cs=0 v=1 pc=0", i, im_cs, inst_valid, inst_pc);
            end
            cyc();
        end
        inst_ready = 1'b1;
        #1;
        checks++; if (im_cs !== 1'b1 || im_address !== 11'd2) begin errors++; $display("FAIL stall_release_issue: got cs=%b addr=%h want cs=1 addr=2", im_cs, im_address); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (inst_valid !== 1'b1 || inst_pc !== AW'(k) || inst !== exp_w[k]) begin
                errors++;
                $display("FAIL stall_seq%0d: got v=%b pc=%h inst=%h want v=1 pc=%h inst=%h", k, inst_valid, inst_pc, inst, k, exp_w[k]);
            end
            cyc();
        end
        $display("test_stall done");
    endtask

    task automatic test_redirect;
        do_reset();
        run = 1'b1; inst_ready = 1'b1;
        cyc();
        cyc();   // read of pc 0 is in flight now
        redirect_valid = 1'b1; redirect_pc = 11'h100;
        #1;
        checks++; if (im_cs !== 1'b0) begin errors++; $display("FAIL redir_no_issue: got cs=%b want 0", im_cs); end
        cyc();
        redirect_valid = 1'b0;
        #1;
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL redir_flush: got v=%b pc=%h want v=0", inst_valid, inst_pc); end
        checks++; if (im_cs !== 1'b1 || im_address !== 11'h100) begin errors++; $display("FAIL redir_issue: got cs=%b addr=%h want cs=1 addr=100", im_cs, im_address); end
        cyc();
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL redir_gap: got v=%b pc=%h want v=0", inst_valid, inst_pc); end
        cyc();
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 11'h100 || inst !== WR) begin
            errors++;
            $display("FAIL redir_target: got v=%b pc=%h inst=%h want v=1 pc=100 inst=%h", inst_valid, inst_pc, inst, WR);
        end
        $display("test_redirect done");
    endtask

    task automatic test_wrap;
        logic [AW-1:0] exp_pc [4];
        logic [W-1:0]  exp_w [4];
        exp_pc = '{11'd2046, 11'd2047, 11'd0, 11'd1};
        exp_w  = '{28'h55007FE, 28'h55007FF, WA, WB};
        do_reset();
        run = 1'b1; inst_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 11'd2046;
        cyc();
        redirect_valid = 1'b0;
        cyc();
        cyc();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (inst_valid !== 1'b1 || inst_pc !== exp_pc[k] || inst !== exp_w[k]) begin
                errors++;
                $display("FAIL wrap_seq%0d: got v=%b pc=%h inst=%h want v=1 pc=%h inst=%h", k, inst_valid, inst_pc, inst, exp_pc[k], exp_w[k]);
            end
            cyc();
        end
        $display("test_wrap done");
    endtask

    task automatic test_run_stop;
        do_reset();
        run = 1'b1; inst_ready = 1'b0;
        cyc();
        cyc();   // read of pc 0 in flight
        run = 1'b0;
        #1;
        checks++; if (im_cs !== 1'b0) begin errors++; $display("FAIL stop_no_issue: got cs=%b want 0", im_cs); end
        cyc();
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (inst_valid !== 1'b1 || inst_pc !== 11'd0 || inst !== WA || im_cs !== 1'b0) begin
                errors++;
                $display("FAIL stop_retain%0d: got v=%b pc=%h inst=%h cs=%b want v=1 pc=0 inst=%h cs=0", i, inst_valid, inst_pc, inst, im_cs, WA);
            end
            cyc();
        end
        $display("test_run_stop done");
    endtask

    task automatic test_reset_full;
        do_reset();
        run = 1'b1; inst_ready = 1'b0;
        repeat (4) cyc();
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 11'd0) begin errors++; $display("FAIL full_pre: got v=%b pc=%h want v=1 pc=0", inst_valid, inst_pc); end
        reset = 1'b1;
        #1;
        checks++; if (inst_valid !== 1'b0 || im_cs !== 1'b0) begin errors++; $display("FAIL full_in_rst: got v=%b cs=%b want v=0 cs=0", inst_valid, im_cs); end
        cyc();
        reset = 1'b0;
        #1;
        checks++;
        if (inst_valid !== 1'b0 || im_cs !== 1'b0 || im_address !== 11'd0) begin
            errors++;
            $display("FAIL full_post_rst: got v=%b cs=%b addr=%h want v=0 cs=0 addr=0", inst_valid, im_cs, im_address);
        end
        cyc();
        #1;
        checks++;
        if (inst_valid !== 1'b0 || im_cs !== 1'b1 || im_address !== 11'd0) begin
            errors++;
            $display("FAIL full_restart: got v=%b cs=%b addr=%h want v=0 cs=1 addr=0", inst_valid, im_cs, im_address);
        end
        $display("test_reset_full done");
    endtask

`ifdef IFETCH_LOADER_EN
    task automatic test_loader;
        do_reset();
        ld_valid = 1'b1; ld_addr = 11'd5; ld_data = 28'hABCDEF1;
        #1;
        checks++; if (ld_ready !== 1'b1 || im_wen !== 2'b00) begin errors++; $display("FAIL ld_ready_idle: got rdy=%b wen=%b want rdy=1 wen=00", ld_ready, im_wen); end
        cyc();
        ld_valid = 1'b0;
        #1;
        checks++;
        if (im_cs !== 1'b1 || im_wen !== 2'b11 || im_address !== 11'd5 || im_d !== 28'hABCDEF1) begin
            errors++;
            $display("FAIL ld_write: got cs=%b wen=%b addr=%h d=%h want cs=1 wen=11 addr=5 d=abcdef1", im_cs, im_wen, im_address, im_d);
        end
        cyc();
        checks++; if (im_cs !== 1'b0 || im_wen !== 2'b00 || im_d !== 28'd0) begin errors++; $display("FAIL ld_one_cycle: got cs=%b wen=%b d=%h want cs=0 wen=00 d=0", im_cs, im_wen, im_d); end
        run = 1'b1; inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 11'd5;
        #1;
        checks++; if (ld_ready !== 1'b0) begin errors++; $display("FAIL ld_ready_run: got %b want 0", ld_ready); end
        cyc();
        redirect_valid = 1'b0;
        #1;
        checks++; if (ld_ready !== 1'b0) begin errors++; $display("FAIL ld_ready_in_run: got %b want 0", ld_ready); end
        cyc();
        cyc();
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 11'd5 || inst !== 28'hABCDEF1) begin
            errors++;
            $display("FAIL ld_fetch: got v=%b pc=%h inst=%h want v=1 pc=5 inst=abcdef1", inst_valid, inst_pc, inst);
        end
        $display("test_loader done");
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_basic();
        test_stall();
        test_redirect();
        test_wrap();
        test_run_stop();
        test_reset_full();
`ifdef IFETCH_LOADER_EN
        test_loader();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
